keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter N, default 32: width of the accumulated entry register `data`; SHALL be a multiple of 4 and at least 8.
REQ-002 Parameter SCAN_DIV, default 50000: clock cycles each row is driven (dwell); SHALL be at least 4.
REQ-003 Parameter DEB_CNT, default 4: number of consecutive matching samples needed to accept a press or a release; SHALL be at least 2.
REQ-004 clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1: reset, asynchronous and active-high.
REQ-006 row  output  4: matrix row drive, active-low, exactly one bit low at all times.
REQ-007 col  input  4: matrix column sense, active-low, asynchronous to clk (board pull-ups).
REQ-008 key_code  output  4: code of the last accepted key.
REQ-009 key_valid  output  1: key_code holds an unconsumed key.
REQ-010 key_ready  input  1: consumer accepts key_code this cycle when key_valid=1.
REQ-011 data  output  N: hex-digit entry register that feeds the display value.
REQ-012 overrun  output  1: sticky flag, a key was accepted while the previous key was still pending.

Function
REQ-013 col SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value (col_s).
REQ-014 The dwell counter SHALL count 0..SCAN_DIV-1; the sample point SHALL be the cycle where the count equals SCAN_DIV-1.
REQ-015 In SCAN the row index SHALL advance 0->1->2->3->0 at each sample point; row = ~(1<<row_idx).
REQ-016 col_idx SHALL be the lowest index with col_s low; a key SHALL be present when any col_s bit is low.
REQ-017 key_code SHALL be {row_idx[1:0], col_idx[1:0]}, so row 2 / col 1 gives 4'h9.
REQ-018 FSM states: SCAN, DEBOUNCE, PRESSED, RELEASE.
REQ-019 SCAN: at a sample point with a key present, capture row_idx and col_idx, hold the row, set deb=1, and go to DEBOUNCE; otherwise advance the row.
REQ-020 DEBOUNCE: at each sample point where the same col_idx is low, increment deb; when deb reaches DEB_CNT, go to PRESSED and accept the key.
REQ-021 DEBOUNCE: at a sample point where no key is present, or a different col_idx is low, go to SCAN and resume from row_idx+1 (mod 4).
REQ-022 PRESSED: the row stays held; at a sample point with no key present, go to RELEASE with deb=1; otherwise stay.
REQ-023 RELEASE: each sample point with no key present increments deb; when deb reaches DEB_CNT, go to SCAN and advance the row; any key present returns the FSM to PRESSED.
REQ-024 Press latency: key_valid and key_code SHALL update on the cycle after the DEB_CNT-th matching sample point.
REQ-025 Accept: data SHALL update to {data[N-5:0], key_code_new} and key_code to key_code_new, both in the same cycle.
REQ-026 Accept while key_valid=1 and key_ready=0: overwrite key_code, keep key_valid=1, and set overrun=1.
REQ-027 key_valid && key_ready with no simultaneous accept: key_valid SHALL be 0 the next cycle.
REQ-028 key_valid && key_ready with a simultaneous accept: key_valid SHALL stay 1, the new code is presented, and overrun is not set.
REQ-029 A held key SHALL produce exactly one accept; there is no auto-repeat.
REQ-030 overrun SHALL clear only on reset.

Reset
REQ-031 On rst=1, immediately and independent of clk: row=4'b1110, key_code=0, key_valid=0, data=0, overrun=0, state=SCAN, row_idx=0, dwell=0, deb=0, synchronizer flops=4'hF.
REQ-032 A reset asserted mid-debounce or mid-press SHALL discard the capture; after release of rst, scanning restarts at row 0.

Structure
REQ-033 A shared package/header SHALL hold the FSM state encodings and the default values of SCAN_DIV and DEB_CNT.
REQ-034 The 2-flop column synchronizer SHALL be a sub-module named key_sync (width parameter, asynchronous reset to all-ones).

Verification (SCAN_DIV=4, DEB_CNT=3, N=32)
REQ-035 Press key row1/col2 and hold -> key_valid rises one cycle after the 3rd matching sample; key_code=4'h6; data=32'h00000006.
REQ-036 Press keys 1, 2, 3, A in turn, key_ready=1, releasing each -> data=32'h0000123A; four single-cycle key_valid pulses; overrun=0.
REQ-037 Glitch col[0] low for one dwell only -> FSM returns to SCAN, no key_valid, data unchanged.
REQ-038 key_ready=0; press 5, release, press 7 -> key_code=4'h7, key_valid=1, overrun=1, data=32'h00000057.
REQ-039 Press cols 1 and 3 together on row 3 -> key_code=4'hD; hold for 20 dwells -> exactly one accept.
REQ-040 Assert rst during DEBOUNCE -> all outputs match their reset values immediately; row 0 is driven; no key is emitted after rst falls.

Source files
------------

// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM encoding, parameter
// defaults and the column priority helper.
package keypad_scanner_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  localparam int SCAN_DIV_DEF = 50000;
  localparam int DEB_CNT_DEF  = 4;

  // Lowest-numbered active-low column wins when several keys share a row.
  function automatic logic [1:0] low_col(input logic [3:0] c);
    logic [1:0] idx;
    idx = 2'd0;
    if (!c[0])      idx = 2'd0;
    else if (!c[1]) idx = 2'd1;
    else if (!c[2]) idx = 2'd2;
    else if (!c[3]) idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for the asynchronous column inputs; resets to the
// idle (all keys up) level.
module key_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce, single accept per press, a
// valid/ready key output and a shifting hex-digit entry register.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int N        = 32,
  parameter int SCAN_DIV = SCAN_DIV_DEF,
  parameter int DEB_CNT  = DEB_CNT_DEF
) (
  input  logic         clk,
  input  logic         rst,
  output logic [3:0]   row,
  input  logic [3:0]   col,
  output logic [3:0]   key_code,
  output logic         key_valid,
  input  logic         key_ready,
  output logic [N-1:0] data,
  output logic         overrun
);

  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = $clog2(DEB_CNT + 1);
  localparam logic [DW-1:0] DWELL_MAX = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DEB_DONE  = BW'(DEB_CNT);

  state_t        state, state_n;
  logic [DW-1:0] dwell;
  logic [1:0]    row_idx, row_idx_n;
  logic [1:0]    cap_col, cap_col_n;
  logic [BW-1:0] deb, deb_n;
  logic [3:0]    col_s;
  logic [1:0]    col_idx;
  logic          key_present;
  logic          sample;
  logic          accept;

  key_sync #(.W(4)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (col),
    .q   (col_s)
  );

  assign col_idx     = low_col(col_s);
  assign key_present = ~&col_s;
  assign sample      = (dwell == DWELL_MAX);
  assign row         = ~(4'b0001 << row_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_SCAN;
      dwell   <= '0;
      row_idx <= 2'd0;
      cap_col <= 2'd0;
      deb     <= '0;
    end else begin
      state   <= state_n;
      dwell   <= sample ? '0 : dwell + DW'(1);
      row_idx <= row_idx_n;
      cap_col <= cap_col_n;
      deb     <= deb_n;
    end
  end

  // Decisions are taken only at the last cycle of each dwell, once the
  // driven row has settled through the synchronizer.
  always_comb begin
    state_n   = state;
    row_idx_n = row_idx;
    cap_col_n = cap_col;
    deb_n     = deb;
    accept    = 1'b0;
    if (sample) begin
      case (state)
        ST_SCAN: begin
          if (key_present) begin
            cap_col_n = col_idx;
            deb_n     = BW'(1);
            state_n   = ST_DEBOUNCE;
          end else begin
            row_idx_n = row_idx + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (key_present && (col_idx == cap_col)) begin
            deb_n = deb + BW'(1);
            if (deb_n == DEB_DONE) begin
              state_n = ST_PRESSED;
              accept  = 1'b1;
            end
          end else begin
            state_n   = ST_SCAN;
            row_idx_n = row_idx + 2'd1;
          end
        end
        ST_PRESSED: begin
          if (!key_present) begin
            state_n = ST_RELEASE;
            deb_n   = BW'(1);
          end
        end
        ST_RELEASE: begin
          if (key_present) begin
            state_n = ST_PRESSED;
          end else begin
            deb_n = deb + BW'(1);
            if (deb_n == DEB_DONE) begin
              state_n   = ST_SCAN;
              row_idx_n = row_idx + 2'd1;
            end
          end
        end
        default: state_n = ST_SCAN;
      endcase
    end
  end

  // A fresh accept always wins over the consumer's handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      data      <= '0;
      overrun   <= 1'b0;
    end else if (accept) begin
      key_code  <= {row_idx, cap_col};
      data      <= {data[N-5:0], row_idx, cap_col};
      key_valid <= 1'b1;
      if (key_valid && !key_ready) overrun <= 1'b1;
    end else if (key_valid && key_ready) begin
      key_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad matrix model drives col from
// row, the stimulus side queues the expected keys, a monitor checks them.
module tb_keypad_scanner;

  localparam int N  = 32;
  localparam int SD = 4;
  localparam int DC = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   row;
  logic [3:0]   col;
  logic [3:0]   key_code;
  logic         key_valid;
  logic         key_ready;
  logic [N-1:0] data;
  logic         overrun;

  logic [15:0]  pressed;
  logic         glitch;
  logic [3:0]   col_m;

  int errors = 0;
  int checks = 0;
  int rises = 0;
  int hi_cycles = 0;

  logic [3:0]   exp_code_q[$];
  logic [N-1:0] exp_data_q[$];
  logic [N-1:0] model_data;

  keypad_scanner #(.N(N), .SCAN_DIV(SD), .DEB_CNT(DC)) dut (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .data      (data),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Keypad matrix: key k sits at row k/4, column k%4.
  always_comb begin
    col_m = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !row[r]) col_m[c] = 1'b0;
    if (glitch) col_m[0] = 1'b0;
  end
  assign col = col_m;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_key(input logic [3:0] k);
    model_data = {model_data[N-5:0], k};
    exp_code_q.push_back(k);
    exp_data_q.push_back(model_data);
  endtask

  task automatic dwells(input int n);
    repeat (n * SD) @(negedge clk);
  endtask

  task automatic press(input int k, input int hold);
    pressed[k] = 1'b1;
    dwells(hold);
    pressed[k] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400 && exp_code_q.size() != 0; i++) @(negedge clk);
    check(name, exp_code_q.size(), 0);
  endtask

  // Monitor: a new key is presented when key_valid rises or data shifts.
  logic         pv;
  logic [N-1:0] pd;
  logic [3:0]   ec;
  logic [N-1:0] ed;
  initial begin
    pv = 1'b0;
    pd = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
        pd = '0;
      end else begin
        if (key_valid) hi_cycles++;
        if (key_valid && !pv) rises++;
        if ((key_valid && !pv) || (data != pd)) begin
          if (exp_code_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_key: got code %0h data %0h, expected no key", key_code, data);
          end else begin
            ec = exp_code_q.pop_front();
            ed = exp_data_q.pop_front();
            check("sb_key_code", key_code, ec);
            check("sb_data", data, ed);
          end
        end
        pv = key_valid;
        pd = data;
      end
    end
  end

  initial begin
    rst = 1'b1;
    key_ready = 1'b1;
    pressed = '0;
    glitch = 1'b0;
    model_data = '0;
    repeat (3) @(negedge clk);
    check("rst_row", row, 4'b1110);
    check("rst_key_code", key_code, 4'h0);
    check("rst_key_valid", key_valid, 1'b0);
    check("rst_data", data, '0);
    check("rst_overrun", overrun, 1'b0);

    // Row1/col2 held from reset release: third matching sample is edge 16.
    pressed[6] = 1'b1;
    expect_key(4'h6);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(posedge clk);
    #1 check("latency_early", key_valid, 1'b0);
    @(posedge clk);
    #1;
    check("latency_valid", key_valid, 1'b1);
    check("latency_code", key_code, 4'h6);
    check("latency_data", data, 32'h6);
    dwells(3);
    pressed[6] = 1'b0;
    dwells(6);
    drain("drain_first");

    // Sequence 1,2,3,A with the consumer always ready.
    do_reset();
    rises = 0;
    hi_cycles = 0;
    foreach (pressed[i]) pressed[i] = 1'b0;
    begin
      int seq [4] = '{1, 2, 3, 10};
      for (int i = 0; i < 4; i++) begin
        expect_key(4'(seq[i]));
        press(seq[i], 10);
        dwells(6);
      end
    end
    drain("drain_seq");
    check("seq_data", data, 32'h0000123A);
    check("seq_rises", rises, 4);
    check("seq_pulse_cycles", hi_cycles, 4);
    check("seq_overrun", overrun, 1'b0);

    // One-dwell glitch on col[0] must not produce a key.
    rises = 0;
    begin
      logic [N-1:0] d0;
      d0 = data;
      glitch = 1'b1;
      repeat (SD) @(negedge clk);
      glitch = 1'b0;
      dwells(8);
      check("glitch_rises", rises, 0);
      check("glitch_data", data, d0);
      check("glitch_valid", key_valid, 1'b0);
    end

    // Overrun: consumer stalled while two keys arrive.
    do_reset();
    key_ready = 1'b0;
    expect_key(4'h5);
    press(5, 10);
    dwells(6);
    expect_key(4'h7);
    press(7, 10);
    dwells(6);
    drain("drain_overrun");
    check("ovr_code", key_code, 4'h7);
    check("ovr_valid", key_valid, 1'b1);
    check("ovr_flag", overrun, 1'b1);
    check("ovr_data", data, 32'h57);
    key_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("ovr_consumed", key_valid, 1'b0);
    check("ovr_sticky", overrun, 1'b1);

    // Two columns on row 3 held for 20 dwells: one accept of the lower column.
    rises = 0;
    key_ready = 1'b0;
    expect_key(4'hD);
    pressed[13] = 1'b1;
    pressed[15] = 1'b1;
    dwells(20);
    pressed[13] = 1'b0;
    pressed[15] = 1'b0;
    dwells(6);
    drain("drain_multi");
    check("multi_rises", rises, 1);
    check("multi_code", key_code, 4'hD);

    // Reset while debouncing a key on row 0.
    for (int i = 0; i < 50 && row == 4'b1110; i++) @(negedge clk);
    for (int i = 0; i < 50 && row != 4'b1110; i++) @(negedge clk);
    check("row0_reached", row, 4'b1110);
    pressed[0] = 1'b1;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_row", row, 4'b1110);
    check("mid_rst_code", key_code, 4'h0);
    check("mid_rst_valid", key_valid, 1'b0);
    check("mid_rst_data", data, '0);
    check("mid_rst_overrun", overrun, 1'b0);
    pressed[0] = 1'b0;
    model_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rises = 0;
    key_ready = 1'b1;
    dwells(10);
    check("post_rst_rises", rises, 0);
    check("post_rst_valid", key_valid, 1'b0);

    // Randomized key sequence against the queue model.
    for (int i = 0; i < 12; i++) begin
      int k;
      k = int'($urandom_range(0, 15));
      expect_key(4'(k));
      press(k, 9 + int'($urandom_range(0, 3)));
      dwells(5 + int'($urandom_range(0, 2)));
    end
    drain("drain_random");
    check("random_data", data, model_data);
    check("random_overrun", overrun, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
